dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Bundle of pipeline-side and memory-side signals for dmem_ctrl.
// The slave modport is the controller's view; master is the pipeline plus memory view.
interface dmem_ctrl_if;
   logic        memread_i;
   logic        memwrite_i;
   logic [31:0] memaddr_i;
   logic [31:0] writedata_i;
   logic [31:0] memdata_o;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   modport slave (
      input  memread_i, memwrite_i, memaddr_i, writedata_i, mem_ack_i, mem_rdata_i,
      output memdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );

   modport master (
      output memread_i, memwrite_i, memaddr_i, writedata_i, mem_ack_i, mem_rdata_i,
      input  memdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: stalls the pipeline around one external access, with timeout.
// Define DMEM_CTRL_WBUF_EN to compile in a one-entry posted write buffer.
module dmem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   dmem_ctrl_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          posted_q, posted_d;   // WR is draining a posted write; doubles as buffer-full flag
   logic          timeout;

   assign timeout = (wait_q == CW'(TIMEOUT_CYC - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         posted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         posted_q <= posted_d;
      end
   end

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      posted_d      = posted_q;
      bus.stall_o   = 1'b0;
      bus.mem_req_o = 1'b0;
      bus.mem_we_o  = 1'b0;

      unique case (state_q)
         IDLE: begin
            wait_d   = '0;
            posted_d = 1'b0;
            if (bus.memwrite_i) begin
               addr_d  = bus.memaddr_i;
               wdata_d = bus.writedata_i;
               state_d = WR;
`ifdef DMEM_CTRL_WBUF_EN
               posted_d = 1'b1;
`else
               bus.stall_o = 1'b1;
`endif
            end else if (bus.memread_i) begin
               addr_d      = bus.memaddr_i;
               state_d     = RD;
               bus.stall_o = 1'b1;
            end
         end

         RD: begin
            bus.mem_req_o = 1'b1;
            bus.stall_o   = 1'b1;
            if (bus.mem_ack_i) begin
               rdata_d = bus.mem_rdata_i;
               state_d = DONE;
            end else if (timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end

         WR: begin
            bus.mem_req_o = 1'b1;
            bus.mem_we_o  = 1'b1;
            // A posted drain only holds back a new access; it returns straight to IDLE
            // so that held access is then serviced in order.
            bus.stall_o   = posted_q ? (bus.memread_i | bus.memwrite_i) : 1'b1;
            if (bus.mem_ack_i || timeout) begin
               if (!bus.mem_ack_i) err_d = 1'b1;
               state_d  = posted_q ? IDLE : DONE;
               posted_d = 1'b0;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.memdata_o   = rdata_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a behavioural memory responder plus a
// transaction-level model of stall length, load data and the sticky error flag.
module tb_dmem_ctrl;

   localparam int TMO = 8;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   dmem_ctrl_if bus ();

   dmem_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ack_delay = 0;
   logic [31:0] rd_value  = '0;
   bit          force_ack = 1'b0;
   int          age       = 0;
   int          req_len   = 0;
   int          unstable  = 0;
   req_t        reqs[$];
   logic [31:0] md_exp    = '0;
   logic        err_exp   = 1'b0;

   // Memory responder: acks after ack_delay wait cycles, logs and watches every request.
   always @(posedge clk_i) begin
      #1;
      if (bus.mem_req_o) begin
         if (age == 0)
            reqs.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
         else if (bus.mem_we_o !== reqs[$].we || bus.mem_addr_o !== reqs[$].addr ||
                  bus.mem_wdata_o !== reqs[$].wdata)
            unstable++;
         bus.mem_ack_i   = (age == ack_delay) || force_ack;
         bus.mem_rdata_i = bus.mem_ack_i ? rd_value : ~rd_value;
         age++;
         req_len = age;
      end else begin
         age             = 0;
         bus.mem_ack_i   = force_ack;
         bus.mem_rdata_i = force_ack ? rd_value : 32'h0;
      end
   end

   // Runs one pipeline access, holding it while stalled; returns what was seen in the release cycle.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int dly, input logic [31:0] rv,
                            output int stalls, output logic [31:0] md,
                            output logic req_at_done);
      bit hung;
      bus.memread_i   = rd;
      bus.memwrite_i  = wr;
      bus.memaddr_i   = a;
      bus.writedata_i = wd;
      ack_delay       = dly;
      rd_value        = rv;
      stalls          = 0;
      md              = 'x;
      req_at_done     = 1'bx;
      hung            = 1'b1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk_i);
         if (bus.stall_o) stalls++;
         else begin
            md          = bus.memdata_o;
            req_at_done = bus.mem_req_o;
            hung        = 1'b0;
            break;
         end
         @(posedge clk_i); #1;
      end
      n_checks++;
      if (hung) begin
         n_fail++;
         $display("FAIL access_bound: stall_o still high after %0d cycles, required release", stalls);
      end
      @(posedge clk_i); #1;
      bus.memread_i  = 1'b0;
      bus.memwrite_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      bus.memread_i = 0; bus.memwrite_i = 0; bus.memaddr_i = 0; bus.writedata_i = 0;
      bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
      @(posedge clk_i); @(posedge clk_i); #1;
      n_checks++;
      if ({bus.stall_o, bus.mem_req_o, bus.mem_we_o, bus.err_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: stall/req/we/err=%b required 0000",
                  {bus.stall_o, bus.mem_req_o, bus.mem_we_o, bus.err_o});
      end
      n_checks++;
      if ({bus.memdata_o, bus.mem_addr_o, bus.mem_wdata_o} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_data: memdata=%h addr=%h wdata=%h required 0",
                  bus.memdata_o, bus.mem_addr_o, bus.mem_wdata_o);
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_read_zero_wait();
      int st; logic [31:0] md; logic rq; int n0;
      n0 = reqs.size();
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hCAFE0001, st, md, rq);
      md_exp = 32'hCAFE0001;
      n_checks++;
      if (st !== 2) begin n_fail++; $display("FAIL read0_stall: got %0d required 2", st); end
      n_checks++;
      if (md !== md_exp) begin n_fail++; $display("FAIL read0_data: got %h required %h", md, md_exp); end
      n_checks++;
      if (reqs.size() !== n0 + 1 || reqs[$].we !== 1'b0 || reqs[$].addr !== 32'h10) begin
         n_fail++;
         $display("FAIL read0_req: count=%0d required 1", reqs.size() - n0);
      end
      n_checks++;
      if (rq !== 1'b0) begin n_fail++; $display("FAIL read0_done_req: got %b required 0", rq); end
   endtask

   task automatic test_write_wait();
      int st; logic [31:0] md; logic rq; int u0;
      u0 = unstable;
      do_access(1'b0, 1'b1, 32'h20, 32'h1234, 3, 32'h5555AAAA, st, md, rq);
      n_checks++;
      if (st !== 5) begin n_fail++; $display("FAIL write3_stall: got %0d required 5", st); end
      n_checks++;
      if (req_len !== 4 || unstable !== u0) begin
         n_fail++;
         $display("FAIL write3_hold: req cycles=%0d unstable=%0d required 4/0", req_len, unstable - u0);
      end
      n_checks++;
      if (reqs[$].we !== 1'b1 || reqs[$].addr !== 32'h20 || reqs[$].wdata !== 32'h1234) begin
         n_fail++;
         $display("FAIL write3_req: we=%b addr=%h data=%h required 1/20/1234",
                  reqs[$].we, reqs[$].addr, reqs[$].wdata);
      end
      n_checks++;
      if (md !== md_exp) begin n_fail++; $display("FAIL write3_memdata: got %h required %h", md, md_exp); end
   endtask

   task automatic test_timeout();
      int st; logic [31:0] md; logic rq;
      do_access(1'b1, 1'b0, 32'h44, 32'h0, 100, 32'h77777777, st, md, rq);
      md_exp = 32'h0; err_exp = 1'b1;
      n_checks++;
      if (st !== TMO + 1 || req_len !== TMO) begin
         n_fail++;
         $display("FAIL timeout_len: stall=%0d req=%0d required %0d/%0d", st, req_len, TMO + 1, TMO);
      end
      n_checks++;
      if (md !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h required 0", md); end
      repeat (3) @(posedge clk_i); #1;
      n_checks++;
      if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", bus.err_o); end
   endtask

   task automatic test_both();
      int st; logic [31:0] md; logic rq; int n0;
      n0 = reqs.size();
      do_access(1'b1, 1'b1, 32'h50, 32'hDEAD, 1, 32'h12121212, st, md, rq);
      n_checks++;
      if (reqs.size() !== n0 + 1 || reqs[$].we !== 1'b1 || reqs[$].addr !== 32'h50) begin
         n_fail++;
         $display("FAIL both_req: count=%0d we=%b required 1 write", reqs.size() - n0, reqs[$].we);
      end
      n_checks++;
      if (st !== 3 || md !== md_exp) begin
         n_fail++;
         $display("FAIL both_stall: stall=%0d memdata=%h required 3/%h", st, md, md_exp);
      end
   endtask

   task automatic test_reset_mid();
      bus.memread_i = 1'b1; bus.memaddr_i = 32'h60; ack_delay = 100;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b1; bus.memread_i = 1'b0;
      @(posedge clk_i); #1;
      md_exp = 32'h0; err_exp = 1'b0;
      n_checks++;
      if (bus.mem_req_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_req: req=%b err=%b required 0/0", bus.mem_req_o, bus.err_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      rd_value = 32'hBADBAD00; force_ack = 1'b1;
      @(negedge clk_i);
      force_ack = 1'b0;
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.memdata_o !== md_exp || bus.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ack: memdata=%h req=%b required %h/0", bus.memdata_o, bus.mem_req_o, md_exp);
      end
   endtask

   task automatic test_random();
      int st; logic [31:0] md; logic rq; int n0; int op; int dly;
      logic [31:0] a, wd, rv;
      int exp_st, exp_len;
      for (int t = 0; t < 40; t++) begin
`ifdef DMEM_CTRL_WBUF_EN
         op = $urandom_range(0, 1);
`else
         op = $urandom_range(0, 3);
`endif
         dly = $urandom_range(0, 10);
         a = $urandom; wd = $urandom; rv = $urandom;
         n0 = reqs.size();
         do_access(op[0], op[1], a, wd, dly, rv, st, md, rq);
         exp_len = (dly < TMO) ? dly + 1 : TMO;
         exp_st  = (op == 0) ? 0 : exp_len + 1;
         if (op == 1) md_exp = (dly < TMO) ? rv : 32'h0;
         if (op != 0 && dly >= TMO) err_exp = 1'b1;
         n_checks++;
         if (st !== exp_st) begin
            n_fail++; $display("FAIL rand_stall[%0d]: got %0d required %0d", t, st, exp_st);
         end
         n_checks++;
         if (md !== md_exp) begin
            n_fail++; $display("FAIL rand_data[%0d]: got %h required %h", t, md, md_exp);
         end
         n_checks++;
         if (bus.err_o !== err_exp) begin
            n_fail++; $display("FAIL rand_err[%0d]: got %b required %b", t, bus.err_o, err_exp);
         end
         n_checks++;
         if (reqs.size() !== n0 + ((op == 0) ? 0 : 1)) begin
            n_fail++; $display("FAIL rand_reqcnt[%0d]: got %0d", t, reqs.size() - n0);
         end else if (op != 0) begin
            n_checks++;
            if (reqs[$].we !== op[1] || reqs[$].addr !== a || (op[1] && reqs[$].wdata !== wd)) begin
               n_fail++;
               $display("FAIL rand_req[%0d]: we=%b addr=%h required %b/%h", t, reqs[$].we, reqs[$].addr, op[1], a);
            end
         end
      end
   endtask

`ifdef DMEM_CTRL_WBUF_EN
   task automatic test_wbuf();
      int st; int n0; logic s0; logic [31:0] rv;
      n0 = reqs.size();
      rv = 32'h0BADF00D;
      bus.memwrite_i = 1'b1; bus.memaddr_i = 32'h30; bus.writedata_i = 32'h77; ack_delay = 2;
      rd_value = rv;
      @(negedge clk_i);
      s0 = bus.stall_o;
      @(posedge clk_i); #1;
      bus.memwrite_i = 1'b0; bus.memread_i = 1'b1; bus.memaddr_i = 32'h40;
      st = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk_i);
         if (!bus.stall_o) break;
         st++;
         @(posedge clk_i); #1;
      end
      md_exp = rv;
      n_checks++;
      if (s0 !== 1'b0) begin n_fail++; $display("FAIL wbuf_post: stall=%b required 0", s0); end
      n_checks++;
      if (st !== 7 || bus.memdata_o !== md_exp) begin
         n_fail++; $display("FAIL wbuf_read: stall=%0d data=%h required 7/%h", st, bus.memdata_o, md_exp);
      end
      n_checks++;
      if (reqs.size() !== n0 + 2 || reqs[n0].we !== 1'b1 || reqs[n0].addr !== 32'h30 ||
          reqs[n0+1].we !== 1'b0 || reqs[n0+1].addr !== 32'h40) begin
         n_fail++; $display("FAIL wbuf_order: %0d requests, write-then-read required", reqs.size() - n0);
      end
      @(posedge clk_i); #1;
      bus.memread_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_read_zero_wait();
`ifndef DMEM_CTRL_WBUF_EN
      test_write_wait();
`endif
      test_timeout();
`ifndef DMEM_CTRL_WBUF_EN
      test_both();
`endif
      test_reset_mid();
      test_random();
`ifdef DMEM_CTRL_WBUF_EN
      test_wbuf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
